// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry {pc, inst} buffer, with redirect/flush handling.
// Optional build macro IFU_JMP_HALT_EN: stop issuing requests after an
// opcode 3'b111 word is pushed, until the next redirect.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request in flight
// REQ     | request in flight, response will be pushed
// DISCARD | request in flight from before a redirect, response dropped
module instr_fetch_unit (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic       inst_valid,
    output logic [7:0] inst,
    output logic [2:0] opcode,
    output logic [7:0] pc_out,
    input  logic       inst_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] fetch_pc_q, fetch_pc_d;
    logic [1:0] count_q, count_d;
    logic [7:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [7:0] ins0_q, ins0_d, ins1_q, ins1_d;

    logic       push;
    logic       pop;
    logic [1:0] count_after;
    logic       space;
    logic       halt_stop;

    assign push        = (state_q == S_REQ) && imem_ack && !redirect;
    assign pop         = (count_q != 2'd0) && inst_ready && !redirect;
    assign count_after = count_q + {1'b0, push} - {1'b0, pop};
    assign space       = (count_after < 2'd2);

`ifdef IFU_JMP_HALT_EN
    logic halt_q, halt_d;

    // Halt latch: set by pushing a jump-class word, cleared by redirect.
    always_comb begin
        halt_d = halt_q;
        if (redirect)
            halt_d = 1'b0;
        else if (push && (imem_data[7:5] == 3'b111))
            halt_d = 1'b1;
    end

    // Halt register.
    always_ff @(posedge clk) begin
        if (rst) halt_q <= 1'b0;
        else     halt_q <= halt_d;
    end

    assign halt_stop = halt_d;
`else
    assign halt_stop = 1'b0;
`endif

    // Buffer update; slot 0 is the head and keeps its value when emptied
    // so inst/pc_out hold while nothing is valid.
    always_comb begin
        count_d = count_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        ins0_d  = ins0_q;
        ins1_d  = ins1_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_after;
            if (pop && (count_q == 2'd2)) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            if (push) begin
                if ((count_q == 2'd0) || pop) begin
                    pc0_d  = addr_q;
                    ins0_d = imem_data;
                end else begin
                    pc1_d  = addr_q;
                    ins1_d = imem_data;
                end
            end
        end
    end

    // Request FSM; a request is only issued when a buffer slot is reserved.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect && space && !halt_stop) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 8'd1;
                        if (space && !halt_stop) begin
                            addr_d = fetch_pc_q + 8'd1;
                        end else begin
                            state_d = S_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    if (!redirect && space && !halt_stop) begin
                        state_d = S_REQ;
                        addr_d  = fetch_pc_q;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= 8'h00;
            fetch_pc_q <= 8'h00;
            count_q    <= 2'd0;
            pc0_q      <= 8'h00;
            pc1_q      <= 8'h00;
            ins0_q     <= 8'h00;
            ins1_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = ins0_q;
    assign pc_out     = pc0_q;
    assign opcode     = ins0_q[7:5];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized
// phase, all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       inst_valid;
    logic [7:0] inst;
    logic [2:0] opcode;
    logic [7:0] pc_out;
    logic       inst_ready;
    logic       redirect;
    logic [7:0] redirect_pc;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .pc_out(pc_out),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stimulus knobs
    int         ready_mode;   // 0 low, 1 high, 2 random
    int         lat;          // cycles of imem_req before ack
    bit         lat_rand;
    bit         jmp_en;
    logic [7:0] jmp_addr;
    bit         redir_req;
    logic [7:0] redir_pc;

    // reference model
    int         cnt;          // buffered instructions
    logic [7:0] exp_fetch;    // address of next accepted response
    logic [7:0] exp_pop;      // pc of buffer head
    bit         stale;        // outstanding request predates a redirect
    int         req_age;
    int         discards;
    logic [7:0] ack_log[$];
    logic [7:0] pop_log[$];

    function automatic logic [7:0] word(input logic [7:0] a);
        if (jmp_en && a == jmp_addr) return 8'hE0;
        return a & 8'h7F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic       ack_now, pop, accepted, hold_chk, was_rst;
        logic [7:0] p_addr, p_inst, p_pc, w;
        if (lat_rand && imem_req === 1'b1 && req_age == 0) lat = $urandom_range(0, 3);
        ack_now   = !rst && (imem_req === 1'b1) && (req_age >= lat);
        imem_ack  = ack_now;
        imem_data = ack_now ? word(imem_addr) : 8'($urandom);
        case (ready_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        redirect    = redir_req;
        redirect_pc = redir_pc;
        redir_req   = 1'b0;
        was_rst     = rst;

        pop = !rst && !redirect && (inst_valid === 1'b1) && inst_ready;
        if (pop) begin
            pop_log.push_back(pc_out);
            exp_pop++;
            cnt--;
        end
        accepted = ack_now && !stale && !redirect;
        if (accepted) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            ack_log.push_back(imem_addr);
            exp_fetch++;
            cnt++;
        end
        if (ack_now && !accepted) discards++;
        if (redirect) begin
            cnt       = 0;
            exp_fetch = redirect_pc;
            exp_pop   = redirect_pc;
            stale     = (imem_req === 1'b1) && !ack_now;
        end else if (ack_now) begin
            stale = 1'b0;
        end
        hold_chk = !rst && (imem_req === 1'b1) && !ack_now;
        p_addr = imem_addr;
        p_inst = inst;
        p_pc   = pc_out;
        if (hold_chk) req_age++;
        else          req_age = 0;
        if (rst) begin
            cnt = 0; exp_fetch = 8'h00; exp_pop = 8'h00; stale = 1'b0; req_age = 0;
        end

        @(posedge clk);
        #1;

        if (was_rst) begin
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_inst", inst, 0);
            chk("rst_opcode", opcode, 0);
            chk("rst_pc", pc_out, 0);
        end
        chk("valid", inst_valid, cnt > 0);
        chk("occupancy", (cnt + int'(imem_req)) <= 2, 1);
        if (cnt > 0) begin
            w = word(exp_pop);
            chk("head_pc", pc_out, exp_pop);
            chk("head_inst", inst, w);
            chk("head_opcode", opcode, w[7:5]);
        end else if (!was_rst) begin
            chk("hold_inst", inst, p_inst);
            chk("hold_pc", pc_out, p_pc);
            chk("hold_opcode", opcode, p_inst[7:5]);
        end
        if (hold_chk) begin
            chk("req_held", imem_req, 1);
            chk("addr_held", imem_addr, p_addr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        ack_log.delete();
        pop_log.delete();
        discards = 0;
    endtask

    initial begin
        bit saw4;
        bit found;
        rst = 1'b1; imem_ack = 1'b0; imem_data = 8'h00; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 8'h00;
        ready_mode = 1; lat = 0; lat_rand = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h03;
        redir_req = 1'b0; redir_pc = 8'h00;
        cnt = 0; exp_fetch = 8'h00; exp_pop = 8'h00; stale = 1'b0; req_age = 0; discards = 0;

        // sequential fetch with immediate acks and a ready consumer
        do_reset();
        cycle();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 8'h00);
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("valid_cont", inst_valid, 1);
        end
        chk("seq_pop_count", pop_log.size() >= 8, 1);
        if (pop_log.size() >= 8)
            for (int k = 0; k < 8; k++) chk("seq_pc", pop_log[k], k);

        // stalled consumer: two accepted fetches, then requests stop
        do_reset();
        ready_mode = 0;
        repeat (10) cycle();
        chk("stall_acks", ack_log.size(), 2);
        chk("stall_req", imem_req, 0);
        ready_mode = 1;
        repeat (6) cycle();
        chk("stall_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            chk("stall_pop0", pop_log[0], 8'h00);
            chk("stall_pop1", pop_log[1], 8'h01);
        end
        chk("resume_acks", ack_log.size() >= 3, 1);
        if (ack_log.size() >= 3) chk("resume_addr", ack_log[2], 8'h02);

        // redirect while the request for 05 waits on a slow memory
        do_reset();
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (imem_req === 1'b1 && imem_addr == 8'h05 && req_age == 0) found = 1'b1;
            else cycle();
        end
        chk("t34_reach05", found, 1);
        ack_log.delete();
        pop_log.delete();
        discards = 0;
        redir_req = 1'b1; redir_pc = 8'h40;
        cycle();
        chk("t34_addr_kept", imem_addr, 8'h05);
        repeat (14) cycle();
        chk("t34_discards", discards, 1);
        chk("t34_acks", ack_log.size() >= 1, 1);
        if (ack_log.size() >= 1) chk("t34_next_addr", ack_log[0], 8'h40);
        chk("t34_pops", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("t34_first_pc", pop_log[0], 8'h40);
        lat = 0;

        // fetch address wraps past FF
        do_reset();
        redir_req = 1'b1; redir_pc = 8'hFE;
        cycle();
        repeat (8) cycle();
        chk("wrap_acks", ack_log.size() >= 3, 1);
        if (ack_log.size() >= 3) begin
            chk("wrap_a0", ack_log[0], 8'hFE);
            chk("wrap_a1", ack_log[1], 8'hFF);
            chk("wrap_a2", ack_log[2], 8'h00);
        end

        // jump opcode at address 03
        do_reset();
        jmp_en = 1'b1;
        repeat (14) cycle();
        saw4 = 1'b0;
        foreach (ack_log[k]) if (ack_log[k] == 8'h04) saw4 = 1'b1;
`ifdef IFU_JMP_HALT_EN
        chk("jmp_no_04", saw4, 0);
        chk("jmp_req_low", imem_req, 0);
        redir_req = 1'b1; redir_pc = 8'h10;
        cycle();
        repeat (4) cycle();
        chk("jmp_resume", ack_log.size() >= 1, 1);
        if (ack_log.size() >= 1) chk("jmp_resume_addr", ack_log[ack_log.size() - 1] >= 8'h10, 1);
`else
        chk("jmp_sees_04", saw4, 1);
`endif
        jmp_en = 1'b0;

        // randomized traffic
        do_reset();
        ready_mode = 2;
        lat_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 6) begin
                redir_req = 1'b1;
                redir_pc  = 8'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 imem_req  out  1  instruction-memory read request, registered.
REQ-005 imem_addr  out  8  read address, registered; stable while imem_req=1.
REQ-006 imem_ack  in  1  read complete; imem_data valid this cycle; ignored while imem_req=0.
REQ-007 imem_data  in  8  fetched instruction word; opcode in [7:5].
REQ-008 inst_valid  out  1  inst, opcode and pc_out hold a valid instruction.
REQ-009 inst  out  8  instruction at the buffer head.
REQ-010 opcode  out  3  inst[7:5]; feeds the control unit opcode input.
REQ-011 pc_out  out  8  address of inst.
REQ-012 inst_ready  in  1  downstream accepts the head when inst_valid=1.
REQ-013 redirect  in  1  one-cycle pulse; flush and restart fetch at redirect_pc.
REQ-014 redirect_pc  in  8  new fetch address, sampled when redirect=1.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, inst}, a fetch_pc register and a 3-state FSM: IDLE, REQ, DISCARD.
REQ-016 IDLE: no request in flight; go to REQ and assert imem_req with imem_addr=fetch_pc next cycle when (FIFO count after this cycle's pop) < 2 and no redirect.
REQ-017 REQ: hold imem_req=1 and imem_addr constant until imem_ack=1; at most one request outstanding.
REQ-018 REQ + imem_ack, no redirect: push {imem_addr, imem_data}, fetch_pc <= fetch_pc+1 (mod 256, 8'hFF wraps to 8'h00), then REQ again if space remains, else IDLE.
REQ-019 An ack in the same cycle as a pop from a full FIFO SHALL be impossible, because a request is issued only when a slot is reserved; occupancy plus outstanding SHALL never exceed 2.
REQ-020 Push-to-visible latency SHALL be 1 cycle: ack at cycle N into an empty FIFO gives inst_valid=1 at N+1.
REQ-021 Pop SHALL occur on inst_valid & inst_ready; simultaneous push and pop keeps count unchanged and order preserved.
REQ-022 redirect SHALL flush the FIFO and set fetch_pc <= redirect_pc; inst_valid=0 from the next cycle; a same-cycle pop or push is dropped.
REQ-023 redirect with a request outstanding and no ack that cycle: go to DISCARD, keeping imem_req and the old imem_addr until imem_ack. That response is dropped, and the FSM then issues a request at the new fetch_pc.
REQ-024 redirect in the same cycle as imem_ack: drop the data, FSM to IDLE; request for redirect_pc issued next cycle.
REQ-025 A redirect while in DISCARD SHALL update fetch_pc only and remain in DISCARD.
REQ-026 While inst_valid=0, inst and pc_out SHALL hold their last values; opcode always equals inst[7:5].

Reset
REQ-027 On rst=1 at a clock edge: imem_req=0, imem_addr=8'h00, fetch_pc=8'h00, FIFO empty, inst_valid=0, inst=8'h00, opcode=3'b000, pc_out=8'h00, FSM=IDLE.
REQ-028 Reset SHALL override redirect and acks; an outstanding request is abandoned and the memory is required to tolerate this.
REQ-029 The first imem_req SHALL assert (addr 8'h00) the cycle after rst deasserts.

Configuration
REQ-030 Macro IFU_JMP_HALT_EN, when defined: after pushing a word with opcode 3'b111, no new request is issued until redirect; entries already queued are unaffected.
REQ-031 Without IFU_JMP_HALT_EN: sequential fetch continues past jumps and relies on redirect to flush.

Verification
REQ-032 Reset, then ack every request after 1 cycle with data=addr, inst_ready=1 -> pc_out/inst sequence 00,01,02,... and inst_valid continuous after the first 2 cycles.
REQ-033 inst_ready=0 throughout -> exactly 2 acks accepted, then imem_req stays 0; raising inst_ready pops 00 then 01 and fetching resumes at 02.
REQ-034 redirect to 8'h40 while a request for 05 is outstanding and the ack is delayed 3 cycles -> addr 05 held until its ack, data discarded, next request addr 40, first valid pc_out=40.
REQ-035 Start fetch_pc at 8'hFE via redirect -> requests FE, FF, 00.
REQ-036 Memory returns 8'hE0 (opcode 111) at addr 03 -> with IFU_JMP_HALT_EN no request for 04 until redirect; without it, request for 04 is issued.
